// File: rtl/rv_wb_timer.sv
// Wishbone B4 pipelined timer: prescaler, 32-bit up-counter with compare/match,
// optional auto-reload on match and a registered level interrupt.
module rv_wb_timer #(
    parameter int unsigned g_presc_width = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        irq_o
);

    localparam logic [g_presc_width-1:0] PCNT_ONE = 1;

    logic                     ack_q, ack_d;
    logic [31:0]              dat_q, dat_d;
    logic [2:0]               ctrl_q, ctrl_d;
    logic [g_presc_width-1:0] presc_q, presc_d;
    logic [g_presc_width-1:0] pcnt_q, pcnt_d;
    logic [31:0]              count_q, count_d;
    logic [31:0]              cmp_q, cmp_d;
    logic                     match_q, match_d;
    logic                     irq_q, irq_d;

    logic        accept, wr, tick, presc_wr, en_rise;
    logic [31:0] rdata, presc_ext, presc_full;
    logic        unused_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        accept    = wb_cyc_i & wb_stb_i;
        wr        = accept & wb_we_i;
        tick      = ctrl_q[0] && (pcnt_q == '0);

        presc_ext = '0;
        presc_ext[g_presc_width-1:0] = presc_q;
        presc_full = merge_bytes(presc_ext, wb_dat_i, wb_sel_i);

        unique case (wb_adr_i[4:2])
            3'd0:    rdata = {29'd0, ctrl_q};
            3'd1:    rdata = presc_ext;
            3'd2:    rdata = count_q;
            3'd3:    rdata = cmp_q;
            3'd4:    rdata = {31'd0, match_q};
            default: rdata = '0;
        endcase

        ctrl_d   = ctrl_q;
        presc_d  = presc_q;
        presc_wr = 1'b0;
        en_rise  = 1'b0;
        cmp_d    = cmp_q;
        if (wr && wb_adr_i[4:2] == 3'd0 && wb_sel_i[0]) begin
            ctrl_d  = wb_dat_i[2:0];
            en_rise = ~ctrl_q[0] & wb_dat_i[0];
        end
        if (wr && wb_adr_i[4:2] == 3'd1 && wb_sel_i != 4'd0) begin
            presc_d  = presc_full[g_presc_width-1:0];
            presc_wr = 1'b1;
        end
        if (wr && wb_adr_i[4:2] == 3'd3) cmp_d = merge_bytes(cmp_q, wb_dat_i, wb_sel_i);

        // Reload (from the value being written, if any) beats the running countdown.
        pcnt_d = pcnt_q;
        if (presc_wr || en_rise)  pcnt_d = presc_d;
        else if (tick)            pcnt_d = presc_q;
        else if (ctrl_q[0])       pcnt_d = pcnt_q - PCNT_ONE;

        count_d = count_q;
        match_d = match_q;
        if (wr && wb_adr_i[4:2] == 3'd4 && wb_sel_i[0] && wb_dat_i[0]) match_d = 1'b0;
        if (tick) begin
            if (count_q == cmp_q) begin
                match_d = 1'b1;
                count_d = ctrl_q[2] ? '0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
        if (wr && wb_adr_i[4:2] == 3'd2 && wb_sel_i != 4'd0)
            count_d = merge_bytes(count_q, wb_dat_i, wb_sel_i);

        ack_d = accept;
        dat_d = (accept && !wb_we_i) ? rdata : '0;
        irq_d = match_q & ctrl_q[1];

        unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], presc_full};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            ctrl_q  <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            irq_q   <= irq_d;
        end
    end

    // An ack whose cycle has been dropped by the initiator is swallowed.
    assign wb_ack_o   = ack_q & wb_cyc_i;
    assign wb_dat_o   = wb_ack_o ? dat_q : '0;
    assign wb_stall_o = 1'b0;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_rv_wb_timer.sv
// Directed bench for rv_wb_timer; bus responses are checked against a
// scoreboard of expected ack cycles and read data.
module tb_rv_wb_timer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_stall_o, irq_o;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    localparam logic [31:0] A_CTRL = 32'h00, A_PRESC = 32'h04, A_COUNT = 32'h08,
                            A_CMP = 32'h0C, A_STAT = 32'h10;

    rv_wb_timer #(.g_presc_width(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitor: every ack must match the oldest scoreboard entry's cycle.
    always @(negedge clk_i) begin
        logic due;
        due = (sb.size() > 0) && (sb[0].cyc == cyc);
        if (wb_ack_o === 1'b1 || due) begin
            n_checks++;
            assert (wb_ack_o === due) else begin
                n_fail++;
                $error("FAIL ack_timing: observed %b expected %b (cycle %0d)", wb_ack_o, due, cyc);
            end
            n_checks++;
            assert (wb_stall_o === 1'b0) else begin
                n_fail++;
                $error("FAIL stall: observed %b expected 0", wb_stall_o);
            end
            if (due) begin
                n_checks++;
                assert (wb_dat_o === sb[0].data) else begin
                    n_fail++;
                    $error("FAIL %s: observed %h expected %h", sb[0].tag, wb_dat_o, sb[0].data);
                end
                void'(sb.pop_front());
            end
        end
    end

    // Drives one request for one cycle; returns #1 after its accept edge.
    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp, input string tag,
                         input bit expect_ack = 1'b1);
        exp_t e;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        if (expect_ack) begin
            e.cyc  = cyc + 1;
            e.data = we ? 32'h0 : exp;
            e.tag  = tag;
            sb.push_back(e);
        end
        @(posedge clk_i); #1;
        wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = '0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input string tag);
        drive(1'b1, adr, dat, 4'hF, 32'h0, tag);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        drive(1'b0, adr, 32'h0, 4'h0, exp, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ack", wb_ack_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_stall", wb_stall_o, 0);
        rst_i = 1'b0;
        wb_cyc_i = 1'b1;
        idle(1);
        rd(A_CTRL, 0, "rst_ctrl");
        rd(A_PRESC, 0, "rst_presc");
        rd(A_COUNT, 0, "rst_count");
        rd(A_CMP, 0, "rst_cmp");
        rd(A_STAT, 0, "rst_status");

        // Byte-lane writes and sel=0
        drive(1'b1, A_CMP, 32'hDEADBEEF, 4'b0101, 0, "cmp_wr_sel");
        rd(A_CMP, 32'h00AD00EF, "cmp_sel_rd");
        drive(1'b1, A_CMP, 32'h12345678, 4'b0000, 0, "cmp_wr_sel0");
        rd(A_CMP, 32'h00AD00EF, "cmp_sel0_rd");
        wr(A_CTRL, 32'hFFFFFFFC, "ctrl_wr");
        wr(A_PRESC, 32'hABCD1234, "presc_wr");
        wr(A_COUNT, 32'h55, "count_wr");
        wr(32'h1C, 32'hFFFFFFFF, "hole_wr");
        idle(2);

        // Pipelined back-to-back reads
        rd(A_CTRL, 32'h4, "pipe_ctrl");
        rd(A_PRESC, 32'h1234, "pipe_presc");
        rd(A_COUNT, 32'h55, "pipe_count");
        rd(32'h18, 32'h0, "pipe_hole18");
        rd(32'h1C, 32'h0, "pipe_hole1c");
        idle(2);

        // Prescaler: ticks every 4 cycles after enable
        wr(A_PRESC, 3, "p_presc");
        wr(A_COUNT, 0, "p_count");
        wr(A_CMP, 32'hFFFFFFFF, "p_cmp");
        wr(A_CTRL, 1, "p_ctrl");
        idle(39);
        rd(A_COUNT, 9, "presc_count40");
        wr(A_CTRL, 0, "p_stop");
        rd(A_COUNT, 10, "presc_count_stop");
        rd(A_STAT, 0, "presc_nomatch");
        idle(2);

        // Match, auto-reload and interrupt
        wr(A_PRESC, 0, "m_presc");
        wr(A_COUNT, 0, "m_count");
        wr(A_CMP, 5, "m_cmp");
        wr(A_CTRL, 7, "m_ctrl");
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_i); #1;
            check($sformatf("irq_rise_k%0d", k), irq_o, (k >= 7) ? 1 : 0);
        end
        wr(A_CTRL, 6, "m_stop");
        rd(A_STAT, 1, "match_set");
        wr(A_STAT, 1, "w1c");
        check("irq_hold", irq_o, 1);
        @(posedge clk_i); #1;
        check("irq_fall", irq_o, 0);
        rd(A_COUNT, 3, "match_count");
        rd(A_STAT, 0, "match_cleared");
        idle(2);

        // Wrap and write-over-tick priority
        wr(A_CTRL, 0, "w_ctrl0");
        wr(A_PRESC, 0, "w_presc");
        wr(A_COUNT, 32'hFFFFFFFF, "w_count");
        wr(A_CTRL, 1, "w_ctrl1");
        idle(1);
        rd(A_COUNT, 0, "wrap_count");
        wr(A_COUNT, 32'h100, "prio_wr");
        rd(A_COUNT, 32'h100, "prio_count");
        wr(A_CTRL, 0, "w_stop");
        rd(A_STAT, 0, "wrap_nomatch");
        idle(2);

        // Ack suppressed when cycle drops
        drive(1'b0, A_CTRL, 0, 4'h0, 0, "supp", 1'b0);
        wb_cyc_i = 1'b0;
        #1;
        check("ack_suppressed", wb_ack_o, 0);
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1;
        idle(2);

        // Reset with a request in flight
        wr(A_PRESC, 32'h22, "r_presc");
        wr(A_CMP, 32'h33, "r_cmp");
        wr(A_CTRL, 1, "r_ctrl");
        idle(2);
        wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = A_COUNT; wb_sel_i = 4'hF;
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async_ack", wb_ack_o, 0);
        check("rst_async_irq", irq_o, 0);
        @(posedge clk_i); #1;
        wb_stb_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst_inflight_ack", wb_ack_o, 0);
        #4;
        rst_i = 1'b0;
        idle(2);
        rd(A_CTRL, 0, "post_rst_ctrl");
        rd(A_PRESC, 0, "post_rst_presc");
        rd(A_COUNT, 0, "post_rst_count");
        rd(A_CMP, 0, "post_rst_cmp");
        rd(A_STAT, 0, "post_rst_status");
        idle(3);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_wb_timer.md
RV_WB_TIMER -- requirements
Module: rv_wb_timer

Interface
REQ-001 SHALL have parameter g_presc_width, default 16: width of the prescaler reload register and the prescaler counter (1..32).
REQ-002 SHALL have port clk_i, input, 1: clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port wb_cyc_i, input, 1: Wishbone cycle.
REQ-005 SHALL have port wb_stb_i, input, 1: Wishbone strobe.
REQ-006 SHALL have port wb_we_i, input, 1: write enable.
REQ-007 SHALL have port wb_sel_i, input, 4: byte selects.
REQ-008 SHALL have port wb_adr_i, input, 32: byte address; only bits [4:2] are decoded.
REQ-009 SHALL have port wb_dat_i, input, 32: write data.
REQ-010 SHALL have port wb_dat_o, output, 32: read data, valid only while wb_ack_o=1.
REQ-011 SHALL have port wb_ack_o, output, 1: Wishbone acknowledge.
REQ-012 SHALL have port wb_stall_o, output, 1: Wishbone stall; tied to 0.
REQ-013 SHALL have port irq_o, output, 1: registered interrupt request, level, active-high.

Function
REQ-014 SHALL implement a Wishbone B4 pipelined responder; a request is accepted in any cycle where wb_cyc_i=1 and wb_stb_i=1.
REQ-015 SHALL assert wb_ack_o for exactly one cycle, the cycle after each accepted request; back-to-back requests get back-to-back acks.
REQ-016 SHALL suppress a pending ack if wb_cyc_i=0 in the ack cycle.
REQ-017 SHALL register wb_dat_o with the register contents at the accept edge; it is 0 when no read is being acked.
REQ-018 SHALL apply writes at the accept edge, per byte lane for each wb_sel_i bit set; wb_sel_i=0 writes nothing but is still acked.
REQ-019 SHALL map registers: 0x00 CTRL (bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD, others read 0); 0x04 PRESC (g_presc_width bits, upper bits read 0); 0x08 COUNT (32 bits, RW); 0x0C COMPARE (32 bits, RW); 0x10 STATUS (bit0 MATCH, write-1-to-clear, write-0 no effect).
REQ-020 SHALL ack accesses to offsets 0x14-0x1C: reads return 0, writes are ignored.
REQ-021 SHALL, while EN=1, decrement the prescaler counter each cycle; a tick occurs in the cycle it equals 0, and it reloads from PRESC in that cycle.
REQ-022 SHALL produce a tick every cycle when PRESC=0, and every PRESC+1 cycles in general.
REQ-023 SHALL reload the prescaler counter from PRESC on any write to PRESC and on a CTRL write that takes EN from 0 to 1.
REQ-024 SHALL hold both counters unchanged while EN=0.
REQ-025 SHALL, on a tick with COUNT==COMPARE, set MATCH; then COUNT becomes 0 if AUTO_RELOAD=1, else COUNT+1.
REQ-026 SHALL, on a tick with COUNT!=COMPARE, increment COUNT modulo 2^32; 0xFFFFFFFF wraps to 0 and does not set MATCH unless it equals COMPARE.
REQ-027 SHALL give a bus write to COUNT priority over a same-cycle tick increment or reload.
REQ-028 SHALL give a same-cycle new MATCH set priority over a write-1-to-clear of STATUS.
REQ-029 SHALL drive irq_o as a flop equal to MATCH AND IRQ_EN of the previous cycle, giving 1 cycle of latency from MATCH/IRQ_EN to irq_o.

Reset
REQ-030 SHALL, while rst_i=1, immediately clear CTRL, PRESC, COUNT, COMPARE, MATCH, the prescaler counter, the pending ack, wb_dat_o, wb_ack_o and irq_o to 0.
REQ-031 SHALL drop any request in flight when rst_i asserts; no ack is issued for it after reset.

Verification
REQ-032 Bus: write COMPARE=0xDEADBEEF with sel=0b0101, then read it -> ack 1 cycle after each stb; read returns 0x00AD00EF.
REQ-033 Pipelining: 4 consecutive stb cycles (read CTRL, PRESC, COUNT, 0x18) -> 4 consecutive acks, 0x18 reads 0, wb_stall_o is 0 throughout.
REQ-034 Prescale: PRESC=3, COUNT=0, COMPARE=0xFFFFFFFF, CTRL=0x1 -> COUNT increments every 4 cycles; after 40 cycles it reads 10 ±1.
REQ-035 Match/IRQ: PRESC=0, COMPARE=5, CTRL=0x7 -> MATCH sets on the tick with COUNT=5, COUNT goes to 0, irq_o rises 1 cycle later; writing STATUS=1 clears MATCH, and irq_o falls 1 cycle after that.
REQ-036 Wrap and priority: COUNT=0xFFFFFFFF, PRESC=0, EN=1 -> next COUNT is 0; a write COUNT=0x100 on a tick cycle -> reads 0x100.
REQ-037 Reset mid-op: assert rst_i during the ack-pending cycle with EN=1 -> no ack; all registers read 0 after release.
